fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the next-generation pipelined RV32 core.
- Replaces the single-cycle combinational IMemory lookup and PC register in the fetch stage.
- Issues in-order requests to a variable-latency instruction memory and buffers returned instructions in a prefetch queue.
- Hands instructions to decode via a valid/ready handshake. Supports redirect (branch/jump) with flush and discard of in-flight stale responses.

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited in-order requests to a variable-latency
// memory, prefetch queue to decode, redirect with stale-response discard.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              QUEUE_DEPTH     = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus_4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_bubble,
  output logic [31:0]     perf_discarded
`endif
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int SW = CW + 1;
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] DEPTH_S = SW'(QUEUE_DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [OW-1:0]   r_outstanding;
  logic [OW-1:0]   r_discard;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [31:0]     r_data_mem [QUEUE_DEPTH];
  logic [XLEN-1:0] r_pc_mem   [QUEUE_DEPTH];

  logic [XLEN-1:0] w_redirect_pc;
  logic [SW-1:0]   w_inflight;
  logic            w_fire;
  logic            w_resp;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic            w_unused_pc_lsbs;

  assign w_redirect_pc    = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_pc_lsbs = ^redirect_pc[1:0];

  // Credit check: every in-flight request already owns a queue slot, so pushes never overflow.
  assign w_inflight     = SW'(r_outstanding) + SW'(r_count);
  assign imem_req_valid = !rst && !redirect_valid && (r_outstanding < MAX_OUT) &&
                          (w_inflight < DEPTH_S);
  assign imem_req_addr  = r_fetch_pc;
  assign w_fire         = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign w_resp = imem_resp_valid && (r_outstanding != '0);
  assign w_drop = w_resp && (redirect_valid || (r_discard != '0));
  assign w_push = w_resp && !w_drop;
  assign w_pop  = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid     = (r_count != '0);
  assign instr           = r_data_mem[r_head];
  assign instr_pc        = r_pc_mem[r_head];
  assign instr_pc_plus_4 = instr_pc + XLEN'(4);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_head        <= '0;
      r_tail        <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle's response is stale.
      r_fetch_pc    <= w_redirect_pc;
      r_resp_pc     <= w_redirect_pc;
      r_outstanding <= r_outstanding - OW'(w_resp);
      r_discard     <= r_outstanding - OW'(w_resp);
      r_count       <= '0;
      r_head        <= '0;
      r_tail        <= '0;
    end else begin
      if (w_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
      r_outstanding <= r_outstanding + OW'(w_fire) - OW'(w_resp);
      if (w_resp && (r_discard != '0)) r_discard <= r_discard - OW'(1);
      if (w_push) begin
        r_resp_pc <= r_resp_pc + XLEN'(4);
        r_tail    <= r_tail + PW'(1);
      end
      if (w_pop) r_head <= r_head + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // NOTE: queue storage is not reset; r_count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data_mem[r_tail] <= imem_resp_data;
      r_pc_mem[r_tail]   <= r_resp_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched   <= '0;
      perf_bubble    <= '0;
      perf_discarded <= '0;
    end else begin
      if (w_pop) perf_fetched <= perf_fetched + 32'd1;
      if (instr_ready && !instr_valid && !redirect_valid) perf_bubble <= perf_bubble + 32'd1;
      if (w_drop) perf_discarded <= perf_discarded + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_resp_has_request: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (r_outstanding != '0));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, directed redirect/stall/wrap sequences and a
// randomized run against a queue-based reference model with an in-order memory model.
module tb_fetch_unit;
  localparam int QD = 4;
  localparam int MO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc, instr_pc_plus_4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubble, perf_discarded;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .QUEUE_DEPTH(QD), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_pc_plus_4(instr_pc_plus_4)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_bubble(perf_bubble), .perf_discarded(perf_discarded)
`endif
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct {
    logic rdv; logic [31:0] rpc; logic rdy; logic mrdy;
    logic e_req; logic [31:0] e_addr; logic e_valid; logic [31:0] e_pc;
  } vec_t;

  req_t        pend[$];  // requests accepted by the memory, oldest first
  ent_t        m_q[$];   // words decode should see, oldest first
  logic [31:0] m_fetch;
  int cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
  int n_tests = 0, n_fail = 0;
  int m_fetched = 0, m_bubble = 0, m_disc = 0;
  logic        s_req_valid, s_ivalid;
  logic [31:0] s_req_addr, s_instr, s_pc, s_pc4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    pend.delete(); m_q.delete(); m_fetch = 32'h0; last_due = 0;
    m_fetched = 0; m_bubble = 0; m_disc = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, play the memory, compare against the model, advance both.
  task automatic step(input logic rdv, input logic [31:0] rpc, input logic rdy, input logic mrdy);
    bit   resp_now, exp_valid, exp_req;
    req_t r;
    int   due;
    @(negedge clk);
    redirect_valid = rdv; redirect_pc = rpc; instr_ready = rdy; imem_req_ready = mrdy;
    resp_now = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? mem_word(pend[0].addr) : $urandom();
    #1;
    s_req_valid = imem_req_valid; s_req_addr = imem_req_addr; s_ivalid = instr_valid;
    s_instr = instr; s_pc = instr_pc; s_pc4 = instr_pc_plus_4;

    exp_valid = (m_q.size() != 0);
    check("instr_valid", 32'(s_ivalid), 32'(exp_valid));
    if (exp_valid) begin
      check("instr_pc", s_pc, m_q[0].pc);
      check("instr", s_instr, m_q[0].data);
      check("instr_pc_plus_4", s_pc4, m_q[0].pc + 32'd4);
    end
    exp_req = !rdv && (pend.size() < MO) && (pend.size() + m_q.size() < QD);
    check("req_valid", 32'(s_req_valid), 32'(exp_req));
    if (exp_req) check("req_addr", s_req_addr, m_fetch);

    if (rdv) begin
      if (resp_now) begin void'(pend.pop_front()); m_disc++; end
      foreach (pend[i]) pend[i].stale = 1'b1;
      m_q.delete();
      m_fetch = {rpc[31:2], 2'b00};
    end else begin
      if (exp_valid && rdy) begin void'(m_q.pop_front()); m_fetched++; end
      if (rdy && !exp_valid) m_bubble++;
      if (resp_now) begin
        r = pend.pop_front();
        if (r.stale) m_disc++;
        else m_q.push_back('{pc: r.addr, data: mem_word(r.addr)});
      end
      if (s_req_valid && mrdy) m_fetch = m_fetch + 32'd4;
    end
    if (s_req_valid && mrdy) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: s_req_addr, due: due, stale: 1'b0});
    end
    cyc++;
  endtask

  task automatic wait_first_valid(input string name, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      seen = s_ivalid;
    end
    check({name, "_seen"}, 32'(seen), 32'h1);
  endtask

  vec_t tbl[9];
  bit   seen;

  initial begin
    // Zero-wait memory, decode always ready, then redirect to 0x200 with a response and a pop.
    tbl[0] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h000, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h004, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h008, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h00C, 1'b1, 32'h4};
    tbl[4] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h010, 1'b1, 32'h8};
    tbl[5] = '{1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 32'h000, 1'b1, 32'hC};
    tbl[6] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0};
    tbl[7] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h204, 1'b0, 32'h0};
    tbl[8] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h208, 1'b1, 32'h200};

    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rdv, tbl[i].rpc, tbl[i].rdy, tbl[i].mrdy);
      check($sformatf("vec%0d_req_valid", i), 32'(s_req_valid), 32'(tbl[i].e_req));
      if (tbl[i].e_req) check($sformatf("vec%0d_req_addr", i), s_req_addr, tbl[i].e_addr);
      check($sformatf("vec%0d_instr_valid", i), 32'(s_ivalid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        check($sformatf("vec%0d_instr_pc", i), s_pc, tbl[i].e_pc);
        check($sformatf("vec%0d_pc_plus_4", i), s_pc4, tbl[i].e_pc + 32'd4);
      end
    end

    // Decode stalled: queue fills to the credit limit, then drains back-to-back.
    do_reset();
    repeat (10) step(1'b0, '0, 1'b0, 1'b1);
    check("stall_req_valid", 32'(s_req_valid), 32'h0);
    check("stall_outstanding", pend.size(), 32'h0);
    check("stall_head_pc", s_pc, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      check($sformatf("drain%0d_valid", k), 32'(s_ivalid), 32'h1);
      check($sformatf("drain%0d_pc", k), s_pc, 32'(k * 4));
      if (k == 1) begin
        check("resume_req_valid", 32'(s_req_valid), 32'h1);
        check("resume_req_addr", s_req_addr, 32'h10);
      end
    end

    // L=3: redirect with two requests in flight.
    do_reset();
    lat_min = 3; lat_max = 3;
    repeat (2) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h100, 1'b1, 1'b1);
    wait_first_valid("redir100", seen);
    check("redir100_first_pc", s_pc, 32'h100);
`ifdef FETCH_PERF_CNT_EN
    check("redir100_perf_discarded", perf_discarded, 32'd2);
`endif

    // L=4: back-to-back redirects, the later one wins.
    do_reset();
    lat_min = 4; lat_max = 4;
    repeat (2) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h300, 1'b1, 1'b1);
    step(1'b1, 32'h400, 1'b1, 1'b1);
    wait_first_valid("redir400", seen);
    check("redir400_first_pc", s_pc, 32'h400);

    // Address wrap and misaligned redirect target.
    do_reset();
    lat_min = 1; lat_max = 1;
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    wait_first_valid("wrap", seen);
    check("wrap_first_pc", s_pc, 32'hFFFF_FFFC);
    check("wrap_first_pc4", s_pc4, 32'h0);
    step(1'b0, '0, 1'b1, 1'b1);
    check("wrap_second_pc", s_pc, 32'h0);
    step(1'b1, 32'h103, 1'b1, 1'b1);
    wait_first_valid("misaligned", seen);
    check("misaligned_first_pc", s_pc, 32'h100);

    // Randomized traffic: variable latency, memory and decode backpressure, redirects.
    do_reset();
    lat_min = 1; lat_max = 5;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99, 0) < 4, $urandom(), $urandom_range(3, 0) != 0,
           $urandom_range(3, 0) != 0);
    end
    @(posedge clk);
    #1;
    check("random_liveness", 32'(m_fetched > 200), 32'h1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, 32'(m_fetched));
    check("perf_bubble", perf_bubble, 32'(m_bubble));
    check("perf_discarded", perf_discarded, 32'(m_disc));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
